ps2_host_cmd_ctrl: RTL and testbench
====================================

// Module: ps2_host_cmd_ctrl
// PURPOSE
//   Sequences one host-to-device PS/2 command byte through ps2_host_tx. Per byte: inhibit
//   ps2_clk, request-to-send, hand-off to the shifter, wait for the device response byte,
//   retry or flag an error. Sits between the CPU/keyboard register block and ps2_host_tx.
//   Drives the clock/data open-drain pull-down enables.
// PARAMETERS
//   CNT_W            20       width of shared cycle timer
//   INHIBIT_CYC      5000     cycles ps2_clk held low before RTS (100us @ 50MHz)
//   RTS_CYC          100      cycles data low with clock still low before clock release
//   XFER_TIMEOUT_CYC 750000   max cycles from clock release to tx_busy fall (15ms)
//   RSP_TIMEOUT_CYC  1000000  max cycles from tx_busy fall to rx_valid (20ms)
//   MAX_RETRY        3        resend attempts after first try (PS2_CMD_RESEND_EN only)
// PORTS
//   sys_clk      in   1  system clock
//   sys_rst_n    in   1  async reset, active low
//   cmd_data     in   8  command byte to send
//   cmd_valid    in   1  command request; accepted when cmd_valid & cmd_ready
//   cmd_ready    out  1  high only in IDLE
//   ps2_clk_oe   out  1  1 = pull ps2_clk low
//   ps2_data_oe  out  1  1 = pull ps2_data low (start bit during RTS)
//   ps2_clk_posedge in 1 synchronised ps2_clk rising edge strobe (shared with ps2_host_tx)
//   tx_data      out  8  byte to ps2_host_tx, held stable from accept to done/error
//   send_req     out  1  one-cycle load strobe to ps2_host_tx
//   tx_busy      in   1  ps2_host_tx busy (frame non-empty)
//   rx_data      in   8  byte from PS/2 receiver
//   rx_valid     in   1  one-cycle receive strobe
//   done         out  1  one-cycle pulse: device answered 0xFA
//   error        out  1  one-cycle pulse: transfer failed; err_code valid same cycle
//   err_code     out  2  0 xfer timeout, 1 rsp timeout, 2 resend exhausted/0xFE, 3 other byte
// BEHAVIOUR
//   Reset (async): state IDLE, timer 0, retry 0; all outputs 0 except cmd_ready=1.
//   IDLE: cmd_ready=1. On accept latch cmd_data->tx_data, retry<=0, timer<=INHIBIT_CYC -> INHIBIT.
//   INHIBIT: clk_oe=1. Timer 0 -> RTS, send_req=1 for exactly this transition cycle, timer<=RTS_CYC.
//   RTS: clk_oe=1, data_oe=1. Timer 0 -> XFER, timer<=XFER_TIMEOUT_CYC.
//   XFER: clk_oe=0; data_oe stays 1 until first ps2_clk_posedge, then 0 (shifter owns line).
//     tx_busy 1->0 -> WAIT_RSP, timer<=RSP_TIMEOUT_CYC. Timer 0 first -> ERR code 0.
//     rx_valid in XFER ignored.
//   WAIT_RSP: rx_valid: 0xFA -> DONE; 0xFE -> RESEND path; any other -> ERR code 3.
//     Timer 0 -> ERR code 1. rx_valid and timer expiry same cycle: rx_valid wins.
//   DONE / ERR: one cycle, pulse done / error, -> IDLE. cmd_ready low in these cycles.
//   Timer: down-counter, saturates at 0, reloaded on every state entry that names a load.
//   Latency min: 1 + INHIBIT_CYC + RTS_CYC + frame + response cycles; no back-to-back accept
//     before DONE/ERR returns to IDLE.
//   cmd_valid outside IDLE ignored (no queuing). tx_busy high on INHIBIT entry: still proceed.
//   Reset mid-operation: both oe drop asynchronously; no done/error pulse emitted.
// CONFIGURATION
//   PS2_CMD_RESEND_EN defined: 0xFE with retry<MAX_RETRY -> retry+1, timer<=INHIBIT_CYC,
//     -> INHIBIT (same tx_data). 0xFE with retry==MAX_RETRY -> ERR code 2.
//   Not defined: 0xFE -> ERR code 2 immediately; retry counter not synthesised.
// STRUCTURE
//   ps2_pkg: state enum (IDLE,INHIBIT,RTS,XFER,WAIT_RSP,DONE,ERR), PS2_RSP_ACK=8'hFA,
//     PS2_RSP_RESEND=8'hFE, err_code localparams.
//   Sub-module ps2_cyc_timer: CNT_W load/decrement/zero-flag counter. FSM stays in this file.
// TESTING (sim params INHIBIT_CYC=8 RTS_CYC=4 XFER_TIMEOUT_CYC=400 RSP_TIMEOUT_CYC=200)
//   Send 0xFF, device model ACKs 0xFA -> clk_oe high 9 cycles, data_oe 4+, one send_req,
//     frame bits 0xFF parity 1, done pulse, cmd_ready back.
//   Device never clocks -> error=1, err_code=0 at cycle 400 after clock release.
//   Frame completes, no response -> error, err_code=1 after 200 cycles.
//   Response 0xFE x4 with RESEND_EN -> 3 re-sends of same byte, then err_code=2;
//     without macro -> err_code=2 after first 0xFE.
//   Response 0xAA -> err_code=3; rx_valid 0xFA same cycle as timer 0 -> done, not error.
//   sys_rst_n low during XFER -> clk_oe/data_oe 0 same cycle, no pulses, cmd_ready=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//   Shared types and constants for the PS/2 host command controller.
//   - ps2_state_e : command sequencer states
//   - PS2_RSP_*   : device response bytes the sequencer reacts to
//   - ERR_*       : err_code values reported with the error pulse
// ---------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      INHIBIT  = 3'd1,
      RTS      = 3'd2,
      XFER     = 3'd3,
      WAIT_RSP = 3'd4,
      DONE     = 3'd5,
      ERR      = 3'd6
   } ps2_state_e;

   localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;

   localparam logic [1:0] ERR_XFER_TIMEOUT = 2'd0;
   localparam logic [1:0] ERR_RSP_TIMEOUT  = 2'd1;
   localparam logic [1:0] ERR_RESEND       = 2'd2;
   localparam logic [1:0] ERR_BAD_RSP      = 2'd3;

endpackage

// File: rtl/ps2_cyc_timer.sv
// ---------------------------------------------------------------------------
// ps2_cyc_timer
//   Loadable down-counter that saturates at zero. A load takes priority over
//   the decrement. zero_o is a plain decode of the current count.
// Ports
//   clk_i       in   clock
//   rst_n_i     in   async reset, active low (count clears to 0)
//   load_i      in   load load_val_i this cycle
//   load_val_i  in   CNT_W value to load
//   cnt_o       out  current count
//   zero_o      out  count == 0
// ---------------------------------------------------------------------------
module ps2_cyc_timer #(
   parameter int CNT_W = 20
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ps2_host_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_host_cmd_ctrl
//   Sequences one host-to-device PS/2 command byte: inhibit the clock line,
//   request-to-send, hand the byte to ps2_host_tx, wait for the device
//   answer, then pulse done or error.
//   Optional feature macro: PS2_CMD_RESEND_EN -- when defined, a 0xFE answer
//   re-sends the same byte up to MAX_RETRY times; otherwise 0xFE is an error.
// Ports
//   sys_clk_i          in   system clock
//   sys_rst_n_i        in   async reset, active low
//   cmd_data_i[7:0]    in   command byte
//   cmd_valid_i        in   command request (taken when cmd_ready_o is high)
//   cmd_ready_o        out  high only in IDLE
//   ps2_clk_oe_o       out  1 = pull ps2_clk low
//   ps2_data_oe_o      out  1 = pull ps2_data low
//   ps2_clk_posedge_i  in   synchronised ps2_clk rising-edge strobe
//   tx_data_o[7:0]     out  byte for ps2_host_tx, stable from accept to end
//   send_req_o         out  one-cycle load strobe to ps2_host_tx
//   tx_busy_i          in   ps2_host_tx busy
//   rx_data_i[7:0]     in   received byte
//   rx_valid_i         in   one-cycle receive strobe
//   done_o             out  one-cycle pulse, device acknowledged
//   error_o            out  one-cycle pulse, transfer failed
//   err_code_o[1:0]    out  failure reason, valid with error_o
//   dbg_state_o[2:0]   out  current sequencer state
// Handshake: cmd_valid_i/cmd_ready_o follow valid/ready -- a command moves
//   on the clock edge where both are high; valid while not ready is ignored.
// ---------------------------------------------------------------------------
module ps2_host_cmd_ctrl
   import ps2_pkg::*;
#(
   parameter int CNT_W            = 20,
   parameter int INHIBIT_CYC      = 5000,
   parameter int RTS_CYC          = 100,
   parameter int XFER_TIMEOUT_CYC = 750000,
   parameter int RSP_TIMEOUT_CYC  = 1000000
`ifdef PS2_CMD_RESEND_EN
   ,
   parameter int MAX_RETRY        = 3
`endif
) (
   input  logic       sys_clk_i,
   input  logic       sys_rst_n_i,
   input  logic [7:0] cmd_data_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   output logic       ps2_clk_oe_o,
   output logic       ps2_data_oe_o,
   input  logic       ps2_clk_posedge_i,
   output logic [7:0] tx_data_o,
   output logic       send_req_o,
   input  logic       tx_busy_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic       done_o,
   output logic       error_o,
   output logic [1:0] err_code_o,
   output logic [2:0] dbg_state_o
);

   ps2_state_e       state_q, state_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic [1:0]       err_q, err_d;
   logic             edge_seen_q, edge_seen_d;
   logic             busy_q;
   logic             busy_fall;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic [CNT_W-1:0] tmr_cnt;
   logic             tmr_zero;

`ifdef PS2_CMD_RESEND_EN
   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RETRY_W-1:0] retry_q, retry_d;
`endif

   ps2_cyc_timer #(.CNT_W(CNT_W)) u_timer (
      .clk_i      (sys_clk_i),
      .rst_n_i    (sys_rst_n_i),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .cnt_o      (tmr_cnt),
      .zero_o     (tmr_zero)
   );

   // The frame is finished when the shifter's busy flag falls; an already
   // high busy at INHIBIT entry is harmless because only the fall matters.
   assign busy_fall = busy_q & ~tx_busy_i;

   always_comb begin
      state_d       = state_q;
      tx_data_d     = tx_data_q;
      err_d         = err_q;
      edge_seen_d   = edge_seen_q;
      tmr_load      = 1'b0;
      tmr_val       = '0;
      cmd_ready_o   = 1'b0;
      ps2_clk_oe_o  = 1'b0;
      ps2_data_oe_o = 1'b0;
      send_req_o    = 1'b0;
      done_o        = 1'b0;
      error_o       = 1'b0;
      err_code_o    = 2'd0;
`ifdef PS2_CMD_RESEND_EN
      retry_d       = retry_q;
`endif
      case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               tx_data_d = cmd_data_i;
`ifdef PS2_CMD_RESEND_EN
               retry_d   = '0;
`endif
               tmr_load  = 1'b1;
               tmr_val   = CNT_W'(INHIBIT_CYC);
               state_d   = INHIBIT;
            end
         end
         INHIBIT: begin
            ps2_clk_oe_o = 1'b1;
            if (tmr_zero) begin
               send_req_o = 1'b1;
               tmr_load   = 1'b1;
               tmr_val    = CNT_W'(RTS_CYC);
               state_d    = RTS;
            end
         end
         RTS: begin
            ps2_clk_oe_o  = 1'b1;
            ps2_data_oe_o = 1'b1;
            if (tmr_zero) begin
               tmr_load    = 1'b1;
               tmr_val     = CNT_W'(XFER_TIMEOUT_CYC);
               edge_seen_d = 1'b0;
               state_d     = XFER;
            end
         end
         XFER: begin
            // Keep the start bit asserted until the device's first clock;
            // after that the shifter drives the data line.
            ps2_data_oe_o = ~edge_seen_q;
            if (ps2_clk_posedge_i) begin
               edge_seen_d = 1'b1;
            end
            if (busy_fall) begin
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(RSP_TIMEOUT_CYC);
               state_d  = WAIT_RSP;
            end else if (tmr_zero) begin
               err_d   = ERR_XFER_TIMEOUT;
               state_d = ERR;
            end
         end
         WAIT_RSP: begin
            // A response arriving on the expiry cycle still counts.
            if (rx_valid_i) begin
               if (rx_data_i == PS2_RSP_ACK) begin
                  state_d = DONE;
               end else if (rx_data_i == PS2_RSP_RESEND) begin
`ifdef PS2_CMD_RESEND_EN
                  if (retry_q < RETRY_W'(MAX_RETRY)) begin
                     retry_d  = retry_q + RETRY_W'(1);
                     tmr_load = 1'b1;
                     tmr_val  = CNT_W'(INHIBIT_CYC);
                     state_d  = INHIBIT;
                  end else begin
                     err_d   = ERR_RESEND;
                     state_d = ERR;
                  end
`else
                  err_d   = ERR_RESEND;
                  state_d = ERR;
`endif
               end else begin
                  err_d   = ERR_BAD_RSP;
                  state_d = ERR;
               end
            end else if (tmr_zero) begin
               err_d   = ERR_RSP_TIMEOUT;
               state_d = ERR;
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         ERR: begin
            error_o    = 1'b1;
            err_code_o = err_q;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         state_q     <= IDLE;
         tx_data_q   <= 8'h00;
         err_q       <= 2'd0;
         edge_seen_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef PS2_CMD_RESEND_EN
         retry_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         err_q       <= err_d;
         edge_seen_q <= edge_seen_d;
         busy_q      <= tx_busy_i;
`ifdef PS2_CMD_RESEND_EN
         retry_q     <= retry_d;
`endif
      end
   end

   assign tx_data_o   = tx_data_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_cmd_ctrl
//   Self-checking bench for ps2_host_cmd_ctrl. The bench plays both the
//   ps2_host_tx shifter and the PS/2 device. A small outcome model predicts,
//   from the list of device answers, how many attempts a command takes and
//   how it ends; the expected outcomes sit in exp_q.
//   Honours PS2_CMD_RESEND_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ps2_host_cmd_ctrl;
   import ps2_pkg::*;

   localparam int CNT_W     = 12;
   localparam int INH       = 8;
   localparam int RTS_C     = 4;
   localparam int XTO       = 400;
   localparam int RTO       = 200;
   localparam int MAX_RETRY = 3;
`ifdef PS2_CMD_RESEND_EN
   localparam bit RESEND_EN = 1'b1;
`else
   localparam bit RESEND_EN = 1'b0;
`endif

   localparam int K_FRAME = 0;
   localparam int K_NOCLK = 1;
   localparam int K_RST   = 2;

   // control vector order: {clk_oe, data_oe, send_req, cmd_ready, done, error}
   localparam logic [5:0] V_IDLE = 6'b000100;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       clk_oe;
   logic       data_oe;
   logic       ps2_clk_posedge;
   logic [7:0] tx_data;
   logic       send_req;
   logic       tx_busy;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       done;
   logic       error;
   logic [1:0] err_code;
   logic [2:0] dbg_state;

   ps2_host_cmd_ctrl #(
      .CNT_W            (CNT_W),
      .INHIBIT_CYC      (INH),
      .RTS_CYC          (RTS_C),
      .XFER_TIMEOUT_CYC (XTO),
      .RSP_TIMEOUT_CYC  (RTO)
   ) dut (
      .sys_clk_i         (clk),
      .sys_rst_n_i       (rst_n),
      .cmd_data_i        (cmd_data),
      .cmd_valid_i       (cmd_valid),
      .cmd_ready_o       (cmd_ready),
      .ps2_clk_oe_o      (clk_oe),
      .ps2_data_oe_o     (data_oe),
      .ps2_clk_posedge_i (ps2_clk_posedge),
      .tx_data_o         (tx_data),
      .send_req_o        (send_req),
      .tx_busy_i         (tx_busy),
      .rx_data_i         (rx_data),
      .rx_valid_i        (rx_valid),
      .done_o            (done),
      .error_o           (error),
      .err_code_o        (err_code),
      .dbg_state_o       (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q[$];      // {attempts[3:0], done, error, err_code[1:0]}
   logic [7:0] rsp_plan[$];   // device answers, one per attempt

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] ctl();
      return {clk_oe, data_oe, send_req, cmd_ready, done, error};
   endfunction

   // Outcome model: walks the answer list the way the protocol describes.
   function automatic logic [7:0] predict(input int kind, input logic [7:0] plan[$]);
      int att = 1;
      if (kind == K_NOCLK) return {4'd1, 2'b01, 2'd0};
      foreach (plan[i]) begin
         if (plan[i] == 8'hFA) begin
            return {4'(att), 2'b10, 2'd0};
         end else if (plan[i] == 8'hFE) begin
            if (RESEND_EN && (att - 1) < MAX_RETRY) att++;
            else return {4'(att), 2'b01, 2'd2};
         end else begin
            return {4'(att), 2'b01, 2'd3};
         end
      end
      return {4'(att), 2'b01, 2'd1};
   endfunction

   task automatic check_outcome(input int attempt);
      logic [7:0] obs;
      logic [7:0] exp;
      obs = {4'(attempt), done, error, err_code};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hFF;
      check("outcome", obs, exp);
   endtask

   // ---------------- driver ----------------
   task automatic run_cmd(input logic [7:0] b, input int kind, input bit tie, input bit busy_early);
      int         attempt;
      int         k0;
      int         pd;
      int         jf;
      int         jn;
      int         d;
      logic [7:0] r;
      bit         fin;
      if (kind != K_RST) exp_q.push_back(predict(kind, rsp_plan));
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_data  = b;
      @(negedge clk);
      check("accept_ready", ctl(), V_IDLE);
      attempt = 1;
      k0      = 0;
      fin     = 1'b0;
      while (!fin) begin
         // INHIBIT then RTS; stray requests must be ignored
         for (int k = k0; k < INH + RTS_C + 2; k++) begin
            @(posedge clk); #1;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_data  = 8'($urandom);
            if (busy_early || k > INH) tx_busy = 1'b1;
            @(negedge clk);
            check("ctl_inh_rts", ctl(), {1'b1, (k > INH), (k == INH), 3'b000});
         end
         cmd_valid = 1'b0;
         if (kind == K_NOCLK) begin
            for (int j = 0; j <= XTO; j++) begin
               @(posedge clk); #1;
               @(negedge clk);
               check("ctl_xfer_noclk", ctl(), 6'b010000);
            end
            @(posedge clk); #1;
            @(negedge clk);
            check_outcome(attempt);
            fin = 1'b1;
         end else if (kind == K_RST) begin
            for (int j = 0; j < 6; j++) begin
               @(posedge clk); #1;
               ps2_clk_posedge = (j == 2);
               @(negedge clk);
               check("ctl_xfer_pre_rst", ctl(), {1'b0, (j <= 2), 4'b0000});
            end
            @(posedge clk); #3;
            rst_n = 1'b0;
            #1;
            check("rst_async_ctl", ctl(), V_IDLE);
            check("rst_tx_data", tx_data, 8'h00);
            check("rst_err_code", err_code, 2'd0);
            ps2_clk_posedge = 1'b0;
            tx_busy         = 1'b0;
            repeat (2) begin
               @(negedge clk);
               check("rst_hold_ctl", ctl(), V_IDLE);
            end
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            check("rst_release_ctl", ctl(), V_IDLE);
            fin = 1'b1;
         end else begin
            // device clocks 11 bits, shifter drops busy afterwards
            check("tx_data_hold", tx_data, b);
            pd = $urandom_range(3, 6);
            jf = 11 * pd + 1;
            jn = $urandom_range(0, jf - 1);
            for (int j = 0; j <= jf; j++) begin
               @(posedge clk); #1;
               ps2_clk_posedge = (j < 11 * pd) && ((j % pd) == pd - 1);
               tx_busy         = (j < jf);
               rx_valid        = (j == jn);
               rx_data         = 8'hFA;
               @(negedge clk);
               check("ctl_xfer", ctl(), {1'b0, (j <= pd - 1), 4'b0000});
            end
            ps2_clk_posedge = 1'b0;
            rx_valid        = 1'b0;
            if (rsp_plan.size() == 0) begin
               for (int w = 0; w <= RTO; w++) begin
                  @(posedge clk); #1;
                  @(negedge clk);
                  check("ctl_wait_norsp", ctl(), 6'b000000);
               end
               @(posedge clk); #1;
               @(negedge clk);
               check_outcome(attempt);
               fin = 1'b1;
            end else begin
               r = rsp_plan.pop_front();
               d = tie ? RTO : $urandom_range(0, RTO - 1);
               for (int w = 0; w <= d; w++) begin
                  @(posedge clk); #1;
                  rx_valid = (w == d);
                  rx_data  = r;
                  @(negedge clk);
                  check("ctl_wait_rsp", ctl(), 6'b000000);
               end
               @(posedge clk); #1;
               rx_valid = 1'b0;
               @(negedge clk);
               if (clk_oe === 1'b1 && attempt < 8) begin
                  check("ctl_retry", ctl(), 6'b100000);
                  attempt++;
                  k0 = 1;
               end else begin
                  check_outcome(attempt);
                  fin = 1'b1;
               end
            end
         end
      end
      tx_busy = 1'b0;
      if (kind != K_RST) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("ctl_idle_back", ctl(), V_IDLE);
      end
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("ctl_idle_gap", ctl(), V_IDLE);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timed out");
   end

   // ---------------- stimulus ----------------
   initial begin
      int sel;
      cmd_valid       = 1'b0;
      cmd_data        = 8'h00;
      ps2_clk_posedge = 1'b0;
      tx_busy         = 1'b0;
      rx_data         = 8'h00;
      rx_valid        = 1'b0;
      rst_n           = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ctl", ctl(), V_IDLE);
      check("reset_tx_data", tx_data, 8'h00);
      check("reset_err_code", err_code, 2'd0);
      check("reset_state", dbg_state, 32'(IDLE));
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_gap(2);

      // 0xFF acknowledged
      rsp_plan = {};
      rsp_plan.push_back(8'hFA);
      run_cmd(8'hFF, K_FRAME, 1'b0, 1'b0);
      idle_gap(1);

      // device never clocks
      rsp_plan = {};
      run_cmd(8'hED, K_NOCLK, 1'b0, 1'b0);

      // frame completes, no answer
      rsp_plan = {};
      run_cmd(8'hF4, K_FRAME, 1'b0, 1'b1);

      // four resend answers
      rsp_plan = {};
      repeat (4) rsp_plan.push_back(8'hFE);
      run_cmd(8'hF3, K_FRAME, 1'b0, 1'b0);

      // unexpected answer
      rsp_plan = {};
      rsp_plan.push_back(8'hAA);
      run_cmd(8'h20, K_FRAME, 1'b0, 1'b0);

      // ACK on the very cycle the response timer runs out
      rsp_plan = {};
      rsp_plan.push_back(8'hFA);
      run_cmd(8'h5A, K_FRAME, 1'b1, 1'b0);

      // reset in the middle of a transfer
      rsp_plan = {};
      run_cmd(8'hEE, K_RST, 1'b0, 1'b0);
      idle_gap(1);

      // randomized commands
      for (int i = 0; i < 8; i++) begin
         rsp_plan = {};
         sel = $urandom_range(0, 4);
         case (sel)
            0: rsp_plan.push_back(8'hFA);
            1: begin rsp_plan.push_back(8'hFE); rsp_plan.push_back(8'hFA); end
            2: rsp_plan.push_back(8'hAA);
            3: rsp_plan.push_back(8'($urandom));
            default: begin
               rsp_plan.push_back(8'hFE);
               rsp_plan.push_back(8'hFE);
               rsp_plan.push_back(8'hFA);
            end
         endcase
         run_cmd(8'($urandom), K_FRAME, 1'($urandom_range(0, 1) == 0 && sel == 0), 1'($urandom_range(0, 1)));
         idle_gap($urandom_range(0, 3));
      end

      check("exp_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
